// File: rtl/kalman_gain_divider.sv
// kalman_gain_divider
//   Unsigned fixed-point divider for the Kalman gain path. The dividend and the
//   divisor arrive on two independent AXI-Stream slave channels, each with a
//   1-entry buffer. The quotient leaves on one AXI-Stream master channel.
//   Sequential radix-2 restoring division retires one quotient bit per clock.
//   Latency is N = DATA_WIDTH+FRAC_BITS edges from the load edge to tvalid, and
//   it does not depend on the operand values.
//
//   Optional feature macro: DIV_ROUND_EN
//     defined   : adds a ROUND state (+1 edge) that rounds the quotient half up
//     undefined : the quotient is truncated toward zero
//
// Ports
//   clk, rst                    clock; synchronous active-low reset
//   s_axis_dividend_*           numerator stream   (tdata/tvalid/tready)
//   s_axis_divisor_*            denominator stream (tdata/tvalid/tready)
//   m_axis_dout_tdata           quotient, Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS
//   m_axis_dout_tuser           [0] divide-by-zero, [1] overflow saturated
//   m_axis_dout_tvalid/tready   result handshake
//   busy                        FSM is not in IDLE
module kalman_gain_divider #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_dividend_tdata,
    input  logic                  s_axis_dividend_tvalid,
    output logic                  s_axis_dividend_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_divisor_tdata,
    input  logic                  s_axis_divisor_tvalid,
    output logic                  s_axis_divisor_tready,
    output logic [DATA_WIDTH-1:0] m_axis_dout_tdata,
    output logic [1:0]            m_axis_dout_tuser,
    output logic                  m_axis_dout_tvalid,
    input  logic                  m_axis_dout_tready,
    output logic                  busy
);

    localparam int N  = DATA_WIDTH + FRAC_BITS;
    localparam int CW = $clog2(N);

`ifdef DIV_ROUND_EN
    typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
`endif

    typedef struct packed {
        logic [1:0]            user;
        logic [DATA_WIDTH-1:0] data;
    } result_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] dvd_buf, dsr_buf;
    logic                  dvd_full, dsr_full;

    logic [N-1:0]          num_sh;   // {dividend, FRAC_BITS zeros}, consumed MSB first
    logic [DATA_WIDTH-1:0] den;
    // Committed remainder is always < den, so DATA_WIDTH bits suffice; the
    // shifted working remainder (rem_sh) carries the extra bit.
    logic [DATA_WIDTH-1:0] rem;
    logic [N-1:0]          quo;
    logic [CW-1:0]         cnt;
    result_t               res;

    logic                  both_full, out_fire, load, last;
    logic [DATA_WIDTH:0]   rem_sh;
    logic                  rem_ge;
    logic [DATA_WIDTH-1:0] rem_nxt;
    logic [N-1:0]          quo_nxt;
    result_t               res_nxt;

    // Saturation and flag encoding shared by truncated and rounded paths.
    // Divide-by-zero wins over overflow so that it reports tuser=01 only.
    function automatic result_t pack_result(input logic [N:0] q, input logic dz);
        result_t r;
        if (dz) begin
            r.user = 2'b01;
            r.data = '1;
        end else if (|(q >> DATA_WIDTH)) begin
            r.user = 2'b10;
            r.data = '1;
        end else begin
            r.user = 2'b00;
            r.data = q[DATA_WIDTH-1:0];
        end
        return r;
    endfunction

    assign both_full = dvd_full & dsr_full;
    assign out_fire  = (state == DONE) & m_axis_dout_tready;
    // A queued pair starts either from IDLE or on the edge the result is taken
    assign load      = both_full & ((state == IDLE) | out_fire);
    assign last      = (cnt == '0);

    assign s_axis_dividend_tready = ~dvd_full;
    assign s_axis_divisor_tready  = ~dsr_full;
    assign m_axis_dout_tdata      = res.data;
    assign m_axis_dout_tuser      = res.user;

    // One restoring step
    always_comb begin
        rem_sh  = {rem, num_sh[N-1]};
        rem_ge  = (rem_sh >= {1'b0, den});
        rem_nxt = rem_ge ? DATA_WIDTH'(rem_sh - {1'b0, den}) : rem_sh[DATA_WIDTH-1:0];
        quo_nxt = {quo[N-2:0], rem_ge};
    end

`ifdef DIV_ROUND_EN
    // Round half up: the discarded fraction is rem/den, so compare 2*rem to den.
    // The extra MSB on the sum catches an increment that wraps DATA_WIDTH bits.
    logic round_up;
    always_comb begin
        round_up = ({rem, 1'b0} >= {1'b0, den});
        res_nxt  = pack_result({1'b0, quo} + (N+1)'(round_up), den == '0);
    end
`else
    always_comb begin
        res_nxt = pack_result({1'b0, quo_nxt}, den == '0);
    end
`endif

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (both_full) state_nxt = CALC;
`ifdef DIV_ROUND_EN
            CALC:  if (last) state_nxt = ROUND;
            ROUND: state_nxt = DONE;
`else
            CALC: if (last) state_nxt = DONE;
`endif
            DONE: if (m_axis_dout_tready) state_nxt = both_full ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        m_axis_dout_tvalid = (state == DONE);
        busy               = (state != IDLE);
    end

    // Operand buffers and datapath
    always_ff @(posedge clk) begin
        if (!rst) begin
            dvd_buf  <= '0;
            dsr_buf  <= '0;
            dvd_full <= 1'b0;
            dsr_full <= 1'b0;
            num_sh   <= '0;
            den      <= '0;
            rem      <= '0;
            quo      <= '0;
            cnt      <= '0;
            res      <= '0;
        end else begin
            // Accept and load are exclusive per buffer: accept needs it empty,
            // load needs it full.
            if (s_axis_dividend_tvalid && !dvd_full) begin
                dvd_buf  <= s_axis_dividend_tdata;
                dvd_full <= 1'b1;
            end else if (load) begin
                dvd_full <= 1'b0;
            end
            if (s_axis_divisor_tvalid && !dsr_full) begin
                dsr_buf  <= s_axis_divisor_tdata;
                dsr_full <= 1'b1;
            end else if (load) begin
                dsr_full <= 1'b0;
            end

            if (load) begin
                num_sh <= N'(dvd_buf) << FRAC_BITS;
                den    <= dsr_buf;
                rem    <= '0;
                quo    <= '0;
                cnt    <= CW'(N - 1);
            end else if (state == CALC) begin
                num_sh <= num_sh << 1;
                rem    <= rem_nxt;
                quo    <= quo_nxt;
                cnt    <= cnt - CW'(1);
`ifndef DIV_ROUND_EN
                if (last) res <= res_nxt;
`endif
            end
`ifdef DIV_ROUND_EN
            else if (state == ROUND) begin
                res <= res_nxt;
            end
`endif
        end
    end

endmodule
